word_byte_serializer: RTL
=========================

WORD_BYTE_SERIALIZER -- requirements
Module: word_byte_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input word width in bits; must be a multiple of 8 and at least 16.
REQ-002 SHALL have parameter LSB_FIRST, default 0: 0 emits the most significant byte first, 1 emits the least significant byte first.
REQ-003 SHALL have parameter CNT_W, default 16: width of the completed-word counter.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port ASYNCRESET, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: input word offered.
REQ-007 SHALL have port in_ready, output, 1 bit: input word accepted this cycle when in_valid is also high.
REQ-008 SHALL have port in_data, input, WIDTH bits: the word to serialize.
REQ-009 SHALL have port out_valid, output, 1 bit: byte offered.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the offered byte.
REQ-011 SHALL have port out_data, output, 8 bits: the current byte.
REQ-012 SHALL have port out_last, output, 1 bit: high on the final byte of a word.
REQ-013 SHALL have port word_count, output, CNT_W bits: number of completed words, modulo 2^CNT_W.

Function
REQ-014 SHALL define NB = WIDTH/8 bytes per word and implement two states, IDLE and SEND.
REQ-015 SHALL define the input handshake as in_valid && in_ready, and the output handshake as out_valid && out_ready.
REQ-016 SHALL drive in_ready = (state == IDLE) || (output handshake && out_last).
- in_ready is combinational from out_ready; this gives zero-bubble back-to-back words.
REQ-017 SHALL, on an input handshake:
- register in_data into the byte shift register;
- set the byte index to 0;
- enter SEND, with out_valid high from the next cycle (latency 1).
REQ-018 SHALL present out_data as a registered value:
- LSB_FIRST=0: byte NB-1-index of the loaded word;
- LSB_FIRST=1: byte index.
REQ-019 SHALL assert out_last exactly when index == NB-1 and out_valid is high.
REQ-020 SHALL hold out_data, out_last and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL, on an output handshake with index < NB-1, advance index by 1 and present the next byte in the following cycle.
REQ-022 SHALL, on an output handshake with out_last:
- increment word_count, wrapping from 2^CNT_W-1 to 0;
- if an input handshake occurs in the same cycle, stay in SEND with the new word's first byte next cycle;
- otherwise go to IDLE with out_valid low.
REQ-023 SHALL ignore in_data changes while in_ready is low; the loaded word is not disturbed.
REQ-024 SHALL treat the SEND transition as TX-side only: the module never drops or repeats a byte, and every accepted word yields exactly NB output handshakes.
REQ-025 SHALL reject illegal parameters at elaboration (WIDTH%8 != 0, WIDTH < 16, CNT_W < 1).

Reset
REQ-026 SHALL, while ASYNCRESET is high, immediately force:
- state = IDLE, out_valid = 0, out_data = 0x00, out_last = 0;
- index = 0, word_count = 0, shift register = 0.
REQ-027 SHALL discard any partially sent word on reset mid-operation; no residual bytes are emitted after release.
REQ-028 SHALL drive in_ready high in the first cycle after reset release.

Structure
REQ-029 SHALL place the state enum, the BYTE_W = 8 constant and the NB derivation in the shared package ser_pkg.
REQ-030 SHALL implement the byte selection and shift register as one sub-module, byte_lane_shifter (load, advance, byte out); control and counter SHALL remain in word_byte_serializer.

Verification
REQ-031 SHALL cover MSB-first order: LSB_FIRST=0, in_data=0xA1B2, out_ready=1 -> 0xA1 (last=0), then 0xB2 (last=1); word_count=1.
REQ-032 SHALL cover LSB-first order: LSB_FIRST=1, in_data=0xA1B2 -> 0xB2, then 0xA1 (last=1).
REQ-033 SHALL cover backpressure: out_ready held low 3 cycles on the first byte of 0xA1B2 -> 0xA1 held stable and in_ready=0 throughout; then 0xB2 follows.
REQ-034 SHALL cover back-to-back words: 0x1122 then 0x3344 with in_valid and out_ready held high -> bytes 11, 22, 33, 44 on four consecutive cycles with no bubble.
REQ-035 SHALL cover reset mid-word: ASYNCRESET pulsed after 0xA1 is accepted -> out_valid drops without a clock edge, 0xB2 never appears, word_count=0; the next word 0x5566 emits 55, 66.
REQ-036 SHALL cover counter wrap: CNT_W=4, 16 words sent -> word_count reads 15 then wraps to 0.

Source files
------------

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and constants for the word-to-byte serializer
package ser_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    function automatic int num_bytes(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/byte_lane_shifter.sv
// rtl/byte_lane_shifter.sv - word holding register that presents one byte lane at a time
module byte_lane_shifter
    import ser_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [WIDTH-1:0]  load_data,
    output logic [BYTE_W-1:0] byte_out
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // The byte on offer always sits at the emitting end, so advancing is a plain shift.
    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = load_data;
        end else if (advance) begin
            word_d = LSB_FIRST ? (word_q >> BYTE_W) : (word_q << BYTE_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign byte_out = LSB_FIRST ? word_q[BYTE_W-1:0] : word_q[WIDTH-1 -: BYTE_W];

endmodule

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - splits WIDTH-bit words into a byte stream and counts completed words
module word_byte_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              ASYNCRESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  word_count
);

    localparam int NB    = num_bytes(WIDTH);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    if ((WIDTH % BYTE_W) != 0 || WIDTH < 16 || CNT_W < 1) begin : g_bad_params
        $error("word_byte_serializer: illegal WIDTH/CNT_W");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_hs;
    logic             in_hs;

    // A new word may be taken in the same cycle the previous word's last byte leaves.
    always_comb begin
        out_hs   = valid_q && out_ready;
        in_ready = (state_q == S_IDLE) || (out_hs && last_q);
        in_hs    = in_valid && in_ready;

        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        if (out_hs) begin
            if (last_q) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d  = idx_q + 1'b1;
                last_d = ((idx_q + 1'b1) == LAST_IDX);
            end
        end

        if (in_hs) begin
            state_d = S_SEND;
            valid_d = 1'b1;
            idx_d   = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    byte_lane_shifter #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_lane (
        .clk       (CLK),
        .rst       (ASYNCRESET),
        .load      (in_hs),
        .advance   (out_hs && !last_q),
        .load_data (in_data),
        .byte_out  (out_data)
    );

    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign word_count = cnt_q;

endmodule
